// File: rtl/paddle_ctrl_if.sv
// rtl/paddle_ctrl_if.sv - paddle controller frame/button inputs and position outputs
// Ports (master drives inputs, slave is the controller):
//   frame_tick, enable, btn_up, btn_down : master -> slave
//   paddle_y[Y_W], moving, at_top, at_bottom : slave -> master
interface paddle_ctrl_if #(
    parameter int Y_W = 10
) ();
    logic           frame_tick;
    logic           enable;
    logic           btn_up;
    logic           btn_down;
    logic [Y_W-1:0] paddle_y;
    logic           moving;
    logic           at_top;
    logic           at_bottom;

    modport master (
        output frame_tick, enable, btn_up, btn_down,
        input  paddle_y, moving, at_top, at_bottom
    );

    modport slave (
        input  frame_tick, enable, btn_up, btn_down,
        output paddle_y, moving, at_top, at_bottom
    );
endinterface

// File: rtl/paddle_ctrl.sv
// rtl/paddle_ctrl.sv - per-frame paddle position with slow/fast acceleration and clamping
// Ports:
//   clk   : system clock
//   rst_n : asynchronous reset, active low (paddle returns to mid-screen)
//   bus   : paddle_ctrl_if.slave (frame_tick/enable/buttons in, position/status out)
module paddle_ctrl #(
    parameter int SCREEN_H    = 480,
    parameter int PADDLE_H    = 80,
    parameter int SLOW_STEP   = 2,
    parameter int FAST_STEP   = 6,
    parameter int HOLD_FRAMES = 15,
    parameter int Y_W         = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    paddle_ctrl_if.slave  bus
);
    localparam int YMAX_I = SCREEN_H - PADDLE_H;
    localparam int HC_W   = $clog2(HOLD_FRAMES + 1);

    localparam logic [Y_W:0]  YMAX = (Y_W+1)'(YMAX_I);
    localparam logic [Y_W:0]  HOME = (Y_W+1)'(YMAX_I / 2);
    localparam logic [Y_W:0]  SLOW = (Y_W+1)'(SLOW_STEP);
    localparam logic [Y_W:0]  FAST = (Y_W+1)'(FAST_STEP);
    localparam logic [HC_W-1:0] HOLD = HC_W'(HOLD_FRAMES);

    typedef enum logic [1:0] {IDLE, SLOW_S, FAST_S} state_t;

    state_t          state_q, state_d;
    logic [HC_W-1:0] hold_q, hold_d;
    logic            dir_q;          // 1 = down
    logic [Y_W-1:0]  y_q;
    logic            moving_q;

    logic            dir_valid;
    logic            dir_dn;
    logic [Y_W:0]    step;
    logic [Y_W:0]    y_ext;
    logic [Y_W:0]    y_sum;
    logic [Y_W:0]    y_d;

    // Both or neither button pressed decodes to "no direction".
    assign dir_valid = bus.btn_up ^ bus.btn_down;
    assign dir_dn    = bus.btn_down;
    assign y_ext     = {1'b0, y_q};
    assign y_sum     = y_ext + step;

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        step    = '0;
        y_d     = y_ext;
        if (!dir_valid) begin
            state_d = IDLE;
            hold_d  = '0;
        end else if (state_q == IDLE || dir_dn != dir_q) begin
            // Fresh press or reversal always restarts the slow phase.
            state_d = SLOW_S;
            hold_d  = HC_W'(1);
            step    = SLOW;
        end else if (state_q == SLOW_S) begin
            step = SLOW;
            if (hold_q != HOLD) begin
                hold_d = hold_q + HC_W'(1);
            end
            if (hold_q + HC_W'(1) == HOLD) begin
                state_d = FAST_S;
            end
        end else begin
            step = FAST;
        end

        // One extra bit of headroom so neither direction can wrap before clamping.
        if (dir_valid) begin
            if (dir_dn) begin
                y_d = (y_sum > YMAX) ? YMAX : y_sum;
            end else begin
                y_d = (y_ext < step) ? '0 : y_ext - step;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            hold_q   <= '0;
            dir_q    <= 1'b0;
            y_q      <= HOME[Y_W-1:0];
            moving_q <= 1'b0;
        end else if (!bus.enable) begin
            // Disable acts on every cycle, not just ticks; position is frozen.
            state_q  <= IDLE;
            hold_q   <= '0;
            moving_q <= 1'b0;
        end else if (bus.frame_tick) begin
            state_q  <= state_d;
            hold_q   <= hold_d;
            if (dir_valid) begin
                dir_q <= dir_dn;
            end
            y_q      <= y_d[Y_W-1:0];
            moving_q <= (y_d != y_ext);
        end
    end

    assign bus.paddle_y  = y_q;
    assign bus.moving    = moving_q;
    assign bus.at_top    = (y_q == '0);
    assign bus.at_bottom = (y_ext == YMAX);
endmodule

// File: tb/tb_paddle_ctrl.sv
// tb/tb_paddle_ctrl.sv - self-checking bench for paddle_ctrl against a run-length reference model
module tb_paddle_ctrl;
    localparam int YMAX  = 400;
    localparam int HOME  = 200;
    localparam int SLOWS = 2;
    localparam int FASTS = 6;
    localparam int HOLDF = 15;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    paddle_ctrl_if #(.Y_W(10)) bus ();

    paddle_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: position plus length of the current same-direction run.
    int m_y;
    int m_run;
    int m_dir;
    int m_mov;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".y"},      int'(bus.paddle_y), m_y);
        check({tag, ".moving"}, int'(bus.moving),   m_mov);
        check({tag, ".top"},    int'(bus.at_top),   (m_y == 0) ? 1 : 0);
        check({tag, ".bottom"}, int'(bus.at_bottom), (m_y == YMAX) ? 1 : 0);
    endtask

    task automatic model_reset();
        m_y = HOME; m_run = 0; m_dir = 0; m_mov = 0;
    endtask

    task automatic model_tick(input bit up, input bit dn);
        int step;
        int ny;
        if (up ^ dn) begin
            if (m_run > 0 && int'(dn) == m_dir) m_run++;
            else m_run = 1;
            m_dir = int'(dn);
            step = (m_run > HOLDF) ? FASTS : SLOWS;
            if (dn) ny = (m_y + step > YMAX) ? YMAX : m_y + step;
            else    ny = (m_y < step) ? 0 : m_y - step;
            m_mov = (ny != m_y) ? 1 : 0;
            m_y = ny;
        end else begin
            m_run = 0;
            m_mov = 0;
        end
    endtask

    // One clock cycle: drive at negedge, model the posedge, compare at next negedge.
    task automatic cycle(input bit tick, input bit up, input bit dn, input bit en);
        @(negedge clk);
        bus.frame_tick = tick;
        bus.btn_up     = up;
        bus.btn_down   = dn;
        bus.enable     = en;
        @(negedge clk);
        if (!en) begin
            m_run = 0;
            m_mov = 0;
        end else if (tick) begin
            model_tick(up, dn);
        end
        bus.frame_tick = 1'b0;
    endtask

    task automatic tick(input bit up, input bit dn, input string tag);
        cycle(1'b1, up, dn, 1'b1);
        check_all(tag);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        bus.frame_tick = 1'b0;
        bus.btn_up = 1'b0;
        bus.btn_down = 1'b0;
        bus.enable = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_all("reset");

        // Up hold from home
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, "up3");
        check("up3.final", int'(bus.paddle_y), 194);

        // Down hold through the slow/fast transition
        rst_n = 1'b0; @(negedge clk); rst_n = 1'b1; model_reset();
        for (int i = 0; i < 17; i++) begin
            tick(1'b0, 1'b1, "dn17");
            if (i == 14) check("dn.tick15", int'(bus.paddle_y), 230);
            if (i == 15) check("dn.tick16", int'(bus.paddle_y), 236);
        end
        check("dn.tick17", int'(bus.paddle_y), 242);

        // Button changes between ticks are ignored
        for (int i = 0; i < 4; i++) cycle(1'b0, i[0], ~i[0], 1'b1);
        check_all("between");

        // Top clamp: walk to 4 with isolated slow steps, then hold up
        while (m_y > 4) begin
            tick(1'b1, 1'b0, "walkup");
            tick(1'b0, 1'b0, "walkidle");
        end
        tick(1'b1, 1'b0, "top1"); check("top1.y", int'(bus.paddle_y), 2);
        tick(1'b1, 1'b0, "top2"); check("top2.y", int'(bus.paddle_y), 0);
        tick(1'b1, 1'b0, "top3"); check("top3.mov", int'(bus.moving), 0);
        check("top3.at_top", int'(bus.at_top), 1);

        // Bottom clamp
        while (m_y < 398) begin
            tick(1'b0, 1'b1, "walkdn");
            tick(1'b0, 1'b0, "walkidle");
        end
        tick(1'b0, 1'b1, "bot1"); check("bot1.y", int'(bus.paddle_y), 400);
        tick(1'b0, 1'b1, "bot2"); check("bot2.mov", int'(bus.moving), 0);
        check("bot2.at_bottom", int'(bus.at_bottom), 1);

        // Both pressed: no movement, then a fresh press is slow
        tick(1'b1, 1'b1, "both1");
        tick(1'b1, 1'b1, "both2");
        check("both.y", int'(bus.paddle_y), 400);
        tick(1'b1, 1'b0, "both.after"); check("both.after.y", int'(bus.paddle_y), 398);

        // Reversal from FAST gives one slow step
        for (int i = 0; i < 18; i++) tick(1'b1, 1'b0, "fastup");
        begin
            int y0;
            y0 = m_y;
            tick(1'b0, 1'b1, "reverse");
            check("reverse.delta", int'(bus.paddle_y), y0 + SLOWS);
        end

        // Asynchronous reset between ticks while in FAST
        for (int i = 0; i < 18; i++) tick(1'b0, 1'b1, "fastdn");
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check("async_rst.y", int'(bus.paddle_y), HOME);
        check("async_rst.mov", int'(bus.moving), 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // Enable dropped mid-hold freezes, re-enable restarts slow
        for (int i = 0; i < 5; i++) tick(1'b0, 1'b1, "hold");
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        check_all("dis.nontick");
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b0, 1'b1, 1'b0);
            check_all("dis.tick");
        end
        tick(1'b0, 1'b1, "reen"); check("reen.y", int'(bus.paddle_y), 210 + SLOWS);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            bit t, u, d, e;
            t = ($urandom_range(0, 2) == 0);
            u = ($urandom_range(0, 3) != 0) ? m_dir[0] == 1'b0 : $urandom_range(0, 1);
            d = ($urandom_range(0, 3) != 0) ? m_dir[0] == 1'b1 : $urandom_range(0, 1);
            if ($urandom_range(0, 40) == 0) begin u = ~u; d = ~d; end
            e = ($urandom_range(0, 31) != 0);
            cycle(t, u, d, e);
            check_all("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        errors++;
        $display("FAIL timeout observed running expected finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "timeout");
    end
endmodule
